microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Parametrised microcoded control unit; next generation of the fixed 16-bit, 4-step CPU control logic.
- Generates the per-cycle control word. It runs a fixed 3-step fetch, then up to STEPS microcode steps indexed by {ireg, step}.
- Additions over the previous generation: writable microcode store, per-word condition field (zero, carry, halt), explicit end marker, hold/stall input, status outputs.
- Sits between the instruction register/flags and all bus-enable signals.

Parameters:
- CTRL_W, 16: control word width.
- OP_W, 8: opcode width (ireg).
- STEPS, 4: execute steps per opcode; power of two, ≥2. SW = clog2(STEPS).
- FETCH0, 'h0001: control word for fetch step 0.
- FETCH1, 'h0002: control word for fetch step 1.
- FETCH2, 'h0001: control word for fetch step 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- hold  in  1  stall request.
- zf  in  1  zero flag.
- cf  in  1  carry flag.
- ireg  in  OP_W  opcode.
- uc_we  in  1  microcode write enable.
- uc_addr  in  OP_W+SW  write address {opcode, step}.
- uc_wdata  in  CTRL_W+3  microword.
- ctrl  out  CTRL_W  registered control word.
- step  out  SW+2  index of word on ctrl (0–2 fetch, 3.. exec).
- instr_done  out  1  pulse: terminating word on ctrl.
- halted  out  1  sequencer halted.

Behaviour:
- Microword layout: [CTRL_W-1:0] ctrl; [CTRL_W+1:CTRL_W] cond; [CTRL_W+2] end.
- cond encoding: 00 none; 01 abort if zf==0; 10 abort if cf==0; 11 halt.
- Store: 2^OP_W × STEPS words, initialised to 0, not cleared by reset.
- Store write: synchronous on uc_we, any state. Same-cycle read of the written address returns old data (read-first).
- Reset (rst==0 at edge): ctrl=0, step=0, instr_done=0, halted=0, state=F0. The next edge outputs FETCH0.
- States: F0, F1, F2, EX(k) for k=0..STEPS-1, HALT. Every edge with rst=1, hold=0 registers the current state's word on ctrl, sets step to match, and advances.
- F0 → F1 → F2 → EX(0); ctrl = FETCH0 / FETCH1 / FETCH2.
- EX(k): word w = store[{ireg,k}]; ctrl = w.ctrl; step = 3+k. ireg is sampled combinationally each EX cycle.
- Next-state priority from EX(k):
  - cond==11 → HALT.
  - cond==01 && zf==0, or cond==10 && cf==0 → F0 (abort).
  - end==1, or (w.ctrl==0 && cond==00) → F0. The zero-word terminator is kept for compatibility.
  - k==STEPS-1 → F0 (forced end).
  - otherwise → EX(k+1).
- A conditional word whose condition passes neither ends nor aborts unless its end bit is set.
- instr_done=1 in the same cycle ctrl carries a word that takes the sequencer to F0 or HALT. Otherwise 0.
- HALT: ctrl=0, step holds, halted=1, instr_done=0. Only reset exits.
- hold=1 at edge: ctrl=0, instr_done=0, state and step unchanged. This inserts a bubble, so no control word is repeated. After hold drops, the next edge issues the pending state's word.
- hold is ignored in HALT and overridden by reset.
- Reset mid-instruction discards progress; the store is kept.

Test Plan:
1. Reset then 3 edges, store all zero → ctrl FETCH0, FETCH1, FETCH2 (step 0, 1, 2). Edge 4: ctrl 0, step 3, instr_done=1. Edge 5: FETCH0.
2. Write op 'h01: {0,00,'h0100}, {0,00,'h0200}, {1,00,'h0400}; ireg='h01 → exec ctrl 'h0100, 'h0200, 'h0400, done on the third; then FETCH0.
3. Op 'h02 step0={0,01,'h8000}, step1={1,00,'h0010}:
   - zf=0 → 'h8000 with done, then FETCH0.
   - zf=1 → 'h8000, then 'h0010 with done.
   - Repeat with cond 10 and cf.
4. Op 'h03 with all STEPS words non-zero, end=0 → 4 exec words, done on step 6, then FETCH0.
5. hold=1 for 2 edges during EX(1) of test 2 → ctrl 0, 0, then 'h0200. The sequence otherwise identical.
6. Op 'h04 step0={0,11,'h0F00} → ctrl 'h0F00 with done, then ctrl 0, halted=1 indefinitely. rst=0 for one edge → halted 0, FETCH0 follows.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Microcoded control unit: fixed 3-step fetch followed by up to STEPS
// writable microcode steps per opcode, with conditional abort/halt support.
module microcode_sequencer #(
  parameter int CTRL_W = 16,
  parameter int OP_W   = 8,
  parameter int STEPS  = 4,
  parameter logic [CTRL_W-1:0] FETCH0 = 'h0001,
  parameter logic [CTRL_W-1:0] FETCH1 = 'h0002,
  parameter logic [CTRL_W-1:0] FETCH2 = 'h0001,
  localparam int SW = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              zf,
  input  logic              cf,
  input  logic [OP_W-1:0]   ireg,
  input  logic              uc_we,
  input  logic [OP_W+SW-1:0] uc_addr,
  input  logic [CTRL_W+2:0] uc_wdata,
  output logic [CTRL_W-1:0] ctrl,
  output logic [SW+1:0]     step,
  output logic              instr_done,
  output logic              halted
);

  localparam int WW    = CTRL_W + 3;
  localparam int DEPTH = 2 ** (OP_W + SW);
  localparam int STW   = SW + 2;

  typedef enum logic [2:0] {F0, F1, F2, EX, HALT} state_t;

  // Power-up contents are zero; reset deliberately leaves the store alone.
  logic [WW-1:0] store [DEPTH] = '{default: '0};

  state_t          state, stateNext;
  logic [SW-1:0]   exk, exkNext;
  logic [CTRL_W-1:0] ctrlNext;
  logic [STW-1:0]  stepNext;
  logic            doneNext, haltedNext;

  logic [WW-1:0]     word;
  logic [CTRL_W-1:0] wCtrl;
  logic [1:0]        cond;
  logic              wEnd, abort;

  always_ff @(posedge clk) begin
    if (uc_we) store[uc_addr] <= uc_wdata;
  end

  assign word  = store[{ireg, exk}];
  assign wCtrl = word[CTRL_W-1:0];
  assign cond  = word[CTRL_W+1:CTRL_W];
  assign wEnd  = word[CTRL_W+2];
  assign abort = (cond == 2'b01 && !zf) || (cond == 2'b10 && !cf);

  always_comb begin
    stateNext  = state;
    exkNext    = exk;
    ctrlNext   = '0;
    stepNext   = step;
    doneNext   = 1'b0;
    haltedNext = halted;
    if (state == HALT) begin
      haltedNext = 1'b1;
    end else if (!hold) begin
      case (state)
        F0: begin
          ctrlNext  = FETCH0;
          stepNext  = STW'(0);
          stateNext = F1;
        end
        F1: begin
          ctrlNext  = FETCH1;
          stepNext  = STW'(1);
          stateNext = F2;
        end
        F2: begin
          ctrlNext  = FETCH2;
          stepNext  = STW'(2);
          stateNext = EX;
          exkNext   = '0;
        end
        EX: begin
          ctrlNext = wCtrl;
          stepNext = STW'(exk) + STW'(3);
          // An all-zero word with no condition still terminates, for legacy microcode.
          if (cond == 2'b11) begin
            stateNext = HALT;
            doneNext  = 1'b1;
          end else if (abort || wEnd || (wCtrl == '0 && cond == 2'b00) ||
                       exk == SW'(STEPS - 1)) begin
            stateNext = F0;
            doneNext  = 1'b1;
          end else begin
            exkNext = exk + SW'(1);
          end
        end
        default: stateNext = F0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= F0;
      exk        <= '0;
      ctrl       <= '0;
      step       <= '0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= stateNext;
      exk        <= exkNext;
      ctrl       <= ctrlNext;
      step       <= stepNext;
      instr_done <= doneNext;
      halted     <= haltedNext;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: expected outputs are queued per edge
// and popped against the DUT outputs one time unit after each rising edge.
module tb_microcode_sequencer;

  localparam int CTRL_W = 16;
  localparam int OP_W   = 8;
  localparam int SW     = 2;
  localparam logic [15:0] F0W = 16'h0001;
  localparam logic [15:0] F1W = 16'h0002;
  localparam logic [15:0] F2W = 16'h0001;

  logic clk = 1'b0;
  logic rst, hold, zf, cf, uc_we;
  logic [OP_W-1:0]    ireg;
  logic [OP_W+SW-1:0] uc_addr;
  logic [CTRL_W+2:0]  uc_wdata;
  logic [CTRL_W-1:0]  ctrl;
  logic [SW+1:0]      step;
  logic instr_done, halted;

  typedef struct packed {
    logic [15:0] c;
    logic [3:0]  s;
    logic        d;
    logic        h;
  } exp_t;

  exp_t sb[$];
  string tags[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk(clk), .rst(rst), .hold(hold), .zf(zf), .cf(cf), .ireg(ireg),
    .uc_we(uc_we), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .ctrl(ctrl), .step(step), .instr_done(instr_done), .halted(halted)
  );

  task automatic checkOutput();
    exp_t e, o;
    string t;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard-empty observed=none expected=entry");
      return;
    end
    e = sb.pop_front();
    t = tags.pop_front();
    o = {ctrl, step, instr_done, halted};
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got ctrl=%h step=%0d done=%b halted=%b, want ctrl=%h step=%0d done=%b halted=%b",
             t, o.c, o.s, o.d, o.h, e.c, e.s, e.d, e.h);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] c, input int s, input logic d,
                               input logic h, input string tag);
    sb.push_back({c, 4'(s), d, h});
    tags.push_back(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic writeWord(input logic [7:0] op, input int k, input logic e,
                           input logic [1:0] cond, input logic [15:0] c);
    uc_we    = 1'b1;
    uc_addr  = {op, 2'(k)};
    uc_wdata = {e, cond, c};
    @(posedge clk);
    #1;
    uc_we = 1'b0;
  endtask

  task automatic fetch(input string tag);
    applyStimulus(F0W, 0, 1'b0, 1'b0, {tag, "-f0"});
    applyStimulus(F1W, 1, 1'b0, 1'b0, {tag, "-f1"});
    applyStimulus(F2W, 2, 1'b0, 1'b0, {tag, "-f2"});
  endtask

  task automatic restart(input string tag);
    rst = 1'b0;
    applyStimulus(16'h0000, 0, 1'b0, 1'b0, {tag, "-reset"});
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; hold = 1'b0; zf = 1'b0; cf = 1'b0; ireg = '0;
    uc_we = 1'b0; uc_addr = '0; uc_wdata = '0;
    @(posedge clk);
    #1;

    // Load the store while the sequencer is held in reset.
    writeWord(8'h01, 0, 1'b0, 2'b00, 16'h0100);
    writeWord(8'h01, 1, 1'b0, 2'b00, 16'h0200);
    writeWord(8'h01, 2, 1'b1, 2'b00, 16'h0400);
    writeWord(8'h02, 0, 1'b0, 2'b01, 16'h8000);
    writeWord(8'h02, 1, 1'b1, 2'b00, 16'h0010);
    writeWord(8'h05, 0, 1'b0, 2'b10, 16'h8000);
    writeWord(8'h05, 1, 1'b1, 2'b00, 16'h0010);
    writeWord(8'h03, 0, 1'b0, 2'b00, 16'h1111);
    writeWord(8'h03, 1, 1'b0, 2'b00, 16'h2222);
    writeWord(8'h03, 2, 1'b0, 2'b00, 16'h3333);
    writeWord(8'h03, 3, 1'b0, 2'b00, 16'h4444);
    writeWord(8'h04, 0, 1'b0, 2'b11, 16'h0F00);

    restart("init");

    ireg = 8'h00;
    fetch("t1");
    applyStimulus(16'h0000, 3, 1'b1, 1'b0, "t1-zero-word");
    applyStimulus(F0W, 0, 1'b0, 1'b0, "t1-refetch");

    restart("t2");
    ireg = 8'h01;
    fetch("t2");
    applyStimulus(16'h0100, 3, 1'b0, 1'b0, "t2-ex0");
    applyStimulus(16'h0200, 4, 1'b0, 1'b0, "t2-ex1");
    applyStimulus(16'h0400, 5, 1'b1, 1'b0, "t2-ex2-end");
    applyStimulus(F0W, 0, 1'b0, 1'b0, "t2-refetch");

    restart("t3a");
    ireg = 8'h02; zf = 1'b0;
    fetch("t3a");
    applyStimulus(16'h8000, 3, 1'b1, 1'b0, "t3a-zf-abort");
    applyStimulus(F0W, 0, 1'b0, 1'b0, "t3a-refetch");

    restart("t3b");
    zf = 1'b1;
    fetch("t3b");
    applyStimulus(16'h8000, 3, 1'b0, 1'b0, "t3b-zf-pass");
    applyStimulus(16'h0010, 4, 1'b1, 1'b0, "t3b-end");
    applyStimulus(F0W, 0, 1'b0, 1'b0, "t3b-refetch");

    restart("t3c");
    ireg = 8'h05; zf = 1'b0; cf = 1'b0;
    fetch("t3c");
    applyStimulus(16'h8000, 3, 1'b1, 1'b0, "t3c-cf-abort");
    applyStimulus(F0W, 0, 1'b0, 1'b0, "t3c-refetch");

    restart("t3d");
    cf = 1'b1;
    fetch("t3d");
    applyStimulus(16'h8000, 3, 1'b0, 1'b0, "t3d-cf-pass");
    applyStimulus(16'h0010, 4, 1'b1, 1'b0, "t3d-end");
    applyStimulus(F0W, 0, 1'b0, 1'b0, "t3d-refetch");

    restart("t4");
    ireg = 8'h03; cf = 1'b0;
    fetch("t4");
    applyStimulus(16'h1111, 3, 1'b0, 1'b0, "t4-ex0");
    applyStimulus(16'h2222, 4, 1'b0, 1'b0, "t4-ex1");
    applyStimulus(16'h3333, 5, 1'b0, 1'b0, "t4-ex2");
    applyStimulus(16'h4444, 6, 1'b1, 1'b0, "t4-forced-end");
    applyStimulus(F0W, 0, 1'b0, 1'b0, "t4-refetch");

    restart("t5");
    ireg = 8'h01;
    fetch("t5");
    applyStimulus(16'h0100, 3, 1'b0, 1'b0, "t5-ex0");
    hold = 1'b1;
    applyStimulus(16'h0000, 3, 1'b0, 1'b0, "t5-bubble1");
    applyStimulus(16'h0000, 3, 1'b0, 1'b0, "t5-bubble2");
    hold = 1'b0;
    applyStimulus(16'h0200, 4, 1'b0, 1'b0, "t5-ex1");
    applyStimulus(16'h0400, 5, 1'b1, 1'b0, "t5-ex2-end");
    applyStimulus(F0W, 0, 1'b0, 1'b0, "t5-refetch");

    restart("t6");
    ireg = 8'h04;
    fetch("t6");
    applyStimulus(16'h0F00, 3, 1'b1, 1'b0, "t6-halt-word");
    applyStimulus(16'h0000, 3, 1'b0, 1'b1, "t6-halted1");
    applyStimulus(16'h0000, 3, 1'b0, 1'b1, "t6-halted2");
    hold = 1'b1;
    applyStimulus(16'h0000, 3, 1'b0, 1'b1, "t6-halted-hold");
    hold = 1'b0;
    applyStimulus(16'h0000, 3, 1'b0, 1'b1, "t6-halted3");
    restart("t6");
    applyStimulus(F0W, 0, 1'b0, 1'b0, "t6-after-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
